// File: rtl/intl_event_log_if.sv
// Interlock event logger bus: interlock state/control in, first-fault and
// FIFO head/status out. The master side is the register file and interlock
// block; the slave side is the logger itself.
interface intl_event_log_if #(
  parameter int STATE_WIDTH = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_WIDTH    = 32
);
  logic [STATE_WIDTH-1:0]        i_intl_state;
  logic                          i_intl_rst;
  logic                          i_pop;
  logic                          o_first_valid;
  logic [STATE_WIDTH-1:0]        o_first_mask;
  logic [TS_WIDTH-1:0]           o_first_ts;
  logic [STATE_WIDTH-1:0]        o_head_mask;
  logic [TS_WIDTH-1:0]           o_head_ts;
  logic [$clog2(FIFO_DEPTH):0]   o_count;
  logic                          o_empty;
  logic                          o_full;
  logic                          o_overflow;
  logic [TS_WIDTH-1:0]           o_timestamp;

  modport master (
    output i_intl_state, i_intl_rst, i_pop,
    input  o_first_valid, o_first_mask, o_first_ts, o_head_mask, o_head_ts,
           o_count, o_empty, o_full, o_overflow, o_timestamp
  );

  modport slave (
    input  i_intl_state, i_intl_rst, i_pop,
    output o_first_valid, o_first_mask, o_first_ts, o_head_mask, o_head_ts,
           o_count, o_empty, o_full, o_overflow, o_timestamp
  );
endinterface

// File: rtl/intl_event_log.sv
// Interlock event logger: rising-edge fault detection, first-fault latch with
// timestamp, and an FWFT FIFO of every fault event for post-trip readout.
module intl_event_log #(
  parameter int STATE_WIDTH = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_WIDTH    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  intl_event_log_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [STATE_WIDTH-1:0] mask;
    logic [TS_WIDTH-1:0]    ts;
  } entry_t;

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic                   first_valid_q, first_valid_d;
  entry_t                 first_q, first_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   empty_q, empty_d, full_q, full_d;
  entry_t                 head_q, head_d;
  entry_t [FIFO_DEPTH-1:0] mem_q;

  logic [STATE_WIDTH-1:0] rise;
  logic                   ev, pop_ok, push_ok;
  entry_t                 new_entry;
  logic [PW-1:0]          wr_base, rd_base;
  logic [CW-1:0]          cnt_base;
  logic                   fv_base, ovf_base;
  entry_t                 first_base;

  // Reset asserts immediately, releases on the second clock edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Edge detect, interlock-reset clear, then push/pop and first-fault update.
  always_comb begin
    rise      = bus.i_intl_state & ~state_q;
    ev        = |rise;
    new_entry = '{mask: rise, ts: ts_q};
    ts_d      = ts_q + TS_WIDTH'(1);
    state_d   = bus.i_intl_state;

    // Interlock reset wipes the log first; a same-cycle event lands on the clean log.
    wr_base    = bus.i_intl_rst ? '0   : wr_ptr_q;
    rd_base    = bus.i_intl_rst ? '0   : rd_ptr_q;
    cnt_base   = bus.i_intl_rst ? '0   : count_q;
    fv_base    = bus.i_intl_rst ? 1'b0 : first_valid_q;
    ovf_base   = bus.i_intl_rst ? 1'b0 : overflow_q;
    first_base = bus.i_intl_rst ? '0   : first_q;

    pop_ok  = bus.i_pop && !bus.i_intl_rst && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = ev && ((cnt_base != CW'(FIFO_DEPTH)) || pop_ok);

    wr_ptr_d = push_ok ? wr_base + PW'(1) : wr_base;
    rd_ptr_d = pop_ok  ? rd_base + PW'(1) : rd_base;
    count_d  = cnt_base + CW'(push_ok) - CW'(pop_ok);
    empty_d  = (count_d == '0);
    full_d   = (count_d == CW'(FIFO_DEPTH));

    overflow_d    = ovf_base | (ev && !push_ok);
    first_valid_d = fv_base | ev;
    first_d       = (ev && !fv_base) ? new_entry : first_base;

    // Head is the post-write view of the read slot; bypass the write that lands there.
    if (count_d == '0)                    head_d = '0;
    else if (push_ok && wr_base == rd_ptr_d) head_d = new_entry;
    else                                  head_d = mem_q[rd_ptr_d];
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q          <= '0;
      state_q       <= '0;
      first_valid_q <= 1'b0;
      first_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      empty_q       <= 1'b1;  // tracks count, which resets to zero
      full_q        <= 1'b0;
      head_q        <= '0;
    end else begin
      ts_q          <= ts_d;
      state_q       <= state_d;
      first_valid_q <= first_valid_d;
      first_q       <= first_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      head_q        <= head_d;
    end
  end

  // Event storage; never read before written thanks to count gating.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_base] <= new_entry;
  end

  assign bus.o_first_valid = first_valid_q;
  assign bus.o_first_mask  = first_q.mask;
  assign bus.o_first_ts    = first_q.ts;
  assign bus.o_head_mask   = head_q.mask;
  assign bus.o_head_ts     = head_q.ts;
  assign bus.o_count       = count_q;
  assign bus.o_empty       = empty_q;
  assign bus.o_full        = full_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_timestamp   = ts_q;
endmodule

// File: tb/tb_intl_event_log.sv
// Bench for intl_event_log: directed scenarios plus a randomized run against
// a queue-based model of the event log; a narrow-timestamp instance covers wrap.
module tb_intl_event_log;
  localparam int SW = 16;
  localparam int D  = 16;
  localparam int TW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  intl_event_log_if #(.STATE_WIDTH(SW), .FIFO_DEPTH(D), .TS_WIDTH(TW)) bus ();
  intl_event_log_if #(.STATE_WIDTH(SW), .FIFO_DEPTH(4), .TS_WIDTH(3))  sm ();

  intl_event_log #(.STATE_WIDTH(SW), .FIFO_DEPTH(D), .TS_WIDTH(TW)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));
  intl_event_log #(.STATE_WIDTH(SW), .FIFO_DEPTH(4), .TS_WIDTH(3)) dut_sm (
    .i_clk(clk), .i_rst(rst), .bus(sm));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [SW-1:0] m;
    logic [TW-1:0] t;
  } ent_t;

  // reference model state
  ent_t          q[$];
  logic [SW-1:0] prev;
  bit            fv;
  logic [SW-1:0] fm;
  logic [TW-1:0] fts;
  bit            ovf;
  logic [TW-1:0] mts;
  ent_t          evs[$];

  logic [136:0] dut_vec;
  assign dut_vec = {bus.o_count, bus.o_head_mask, bus.o_head_ts, bus.o_first_valid,
                    bus.o_first_mask, bus.o_first_ts, bus.o_overflow, bus.o_empty,
                    bus.o_full, bus.o_timestamp};

  task automatic model_reset();
    q.delete(); prev = '0; fv = 0; fm = '0; fts = '0; ovf = 0; mts = '0;
  endtask

  task automatic model_step();
    logic [SW-1:0] rise;
    rise = bus.i_intl_state & ~prev;
    prev = bus.i_intl_state;
    if (bus.i_intl_rst) begin
      q.delete(); fv = 0; fm = '0; fts = '0; ovf = 0;
    end else if (bus.i_pop && q.size() > 0) begin
      void'(q.pop_front());
    end
    if (rise != '0) begin
      if (!fv) begin fv = 1; fm = rise; fts = mts; end
      if (q.size() < D) q.push_back('{rise, mts});
      else ovf = 1;
    end
    mts = mts + 1;
  endtask

  function automatic logic [136:0] exp_vec();
    logic [SW-1:0] hm;
    logic [TW-1:0] ht;
    hm = '0; ht = '0;
    if (q.size() > 0) begin hm = q[0].m; ht = q[0].t; end
    return {5'(q.size()), hm, ht, fv, fm, fts, ovf, q.size() == 0, q.size() == D, mts};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_log();
    bus.i_intl_rst = 1'b1; tick(); bus.i_intl_rst = 1'b0;
  endtask

  task automatic add_event();
    logic [SW-1:0] m;
    m = SW'($urandom_range(1, 65535));
    bus.i_intl_state = m;
    evs.push_back('{m, mts});
    tick();
    bus.i_intl_state = '0;
    tick();
  endtask

  task automatic test_reset();
    bus.i_intl_state = '0; bus.i_intl_rst = 0; bus.i_pop = 0;
    sm.i_intl_state = '0; sm.i_intl_rst = 0; sm.i_pop = 0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dut_vec !== exp_vec()) begin failures++;
      $display("FAIL reset_state: got %h exp %h", dut_vec, exp_vec()); end
    checks++; if (sm.o_count !== 3'd0 || sm.o_empty !== 1'b1) begin failures++;
      $display("FAIL reset_small: got count %0d empty %b exp 0 1", sm.o_count, sm.o_empty); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.o_timestamp !== 32'd0) begin failures++;
      $display("FAIL reset_release_ts: got %0d exp 0", bus.o_timestamp); end
    tick();
    checks++; if (bus.o_timestamp !== 32'd1) begin failures++;
      $display("FAIL ts_first_inc: got %0d exp 1", bus.o_timestamp); end
  endtask

  task automatic test_first_fault();
    while (mts != 32'd10) tick();
    bus.i_intl_state = 16'h0004;
    tick();
    checks++; if (bus.o_first_valid !== 1'b1 || bus.o_first_mask !== 16'h0004) begin failures++;
      $display("FAIL ff_first_mask: got v=%b %h exp v=1 0004", bus.o_first_valid, bus.o_first_mask); end
    checks++; if (bus.o_first_ts !== 32'd10) begin failures++;
      $display("FAIL ff_first_ts: got %0d exp 10", bus.o_first_ts); end
    checks++; if (bus.o_count !== 5'd1 || bus.o_head_mask !== 16'h0004 || bus.o_head_ts !== 32'd10) begin
      failures++;
      $display("FAIL ff_head: got count %0d mask %h ts %0d exp 1 0004 10",
               bus.o_count, bus.o_head_mask, bus.o_head_ts); end
    repeat (100) tick();
    checks++; if (bus.o_count !== 5'd1 || bus.o_empty !== 1'b0) begin failures++;
      $display("FAIL ff_held_high: got count %0d empty %b exp 1 0", bus.o_count, bus.o_empty); end
  endtask

  task automatic test_two_events();
    logic [TW-1:0] t0;
    bus.i_intl_state = '0;
    clear_log();
    bus.i_intl_state = 16'h0003; t0 = mts;
    tick(); tick(); tick();
    bus.i_intl_state = 16'h0083;
    tick();
    checks++; if (bus.o_count !== 5'd2 || bus.o_head_mask !== 16'h0003 || bus.o_head_ts !== t0) begin
      failures++;
      $display("FAIL two_head0: got count %0d mask %h ts %0d exp 2 0003 %0d",
               bus.o_count, bus.o_head_mask, bus.o_head_ts, t0); end
    checks++; if (bus.o_first_mask !== 16'h0003 || bus.o_first_ts !== t0) begin failures++;
      $display("FAIL two_first: got %h %0d exp 0003 %0d", bus.o_first_mask, bus.o_first_ts, t0); end
    bus.i_pop = 1'b1; tick(); bus.i_pop = 1'b0;
    checks++; if (bus.o_count !== 5'd1 || bus.o_head_mask !== 16'h0080 || bus.o_head_ts !== t0 + 3) begin
      failures++;
      $display("FAIL two_head1: got count %0d mask %h ts %0d exp 1 0080 %0d",
               bus.o_count, bus.o_head_mask, bus.o_head_ts, t0 + 3); end
    bus.i_pop = 1'b1; tick(); bus.i_pop = 1'b0;
    checks++; if (bus.o_empty !== 1'b1 || bus.o_head_mask !== 16'h0 || bus.o_head_ts !== 32'd0) begin
      failures++;
      $display("FAIL two_drain: got empty %b mask %h ts %0d exp 1 0 0",
               bus.o_empty, bus.o_head_mask, bus.o_head_ts); end
    bus.i_pop = 1'b1; tick(); bus.i_pop = 1'b0;
    checks++; if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1 || bus.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL two_pop_empty: got count %0d empty %b ovf %b exp 0 1 0",
               bus.o_count, bus.o_empty, bus.o_overflow); end
  endtask

  task automatic test_overflow();
    bus.i_intl_state = '0;
    clear_log();
    evs.delete();
    repeat (17) add_event();
    checks++; if (bus.o_count !== 5'd16 || bus.o_full !== 1'b1 || bus.o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_status: got count %0d full %b ovf %b exp 16 1 1",
               bus.o_count, bus.o_full, bus.o_overflow); end
    checks++; if (bus.o_first_mask !== evs[0].m || bus.o_first_ts !== evs[0].t) begin failures++;
      $display("FAIL ovf_first: got %h %0d exp %h %0d", bus.o_first_mask, bus.o_first_ts,
               evs[0].m, evs[0].t); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.o_head_mask !== evs[i].m || bus.o_head_ts !== evs[i].t) begin failures++;
        $display("FAIL ovf_order[%0d]: got %h %0d exp %h %0d", i, bus.o_head_mask, bus.o_head_ts,
                 evs[i].m, evs[i].t); end
      bus.i_pop = 1'b1; tick(); bus.i_pop = 1'b0;
    end
    checks++; if (bus.o_empty !== 1'b1 || bus.o_overflow !== 1'b1 || bus.o_full !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky: got empty %b ovf %b full %b exp 1 1 0",
               bus.o_empty, bus.o_overflow, bus.o_full); end
  endtask

  task automatic test_push_pop_full();
    logic [SW-1:0] m;
    logic [TW-1:0] t;
    bus.i_intl_state = '0;
    clear_log();
    evs.delete();
    repeat (16) add_event();
    m = SW'($urandom_range(1, 65535)); t = mts;
    bus.i_intl_state = m; bus.i_pop = 1'b1;
    tick();
    bus.i_intl_state = '0; bus.i_pop = 1'b0;
    checks++; if (bus.o_count !== 5'd16 || bus.o_overflow !== 1'b0 || bus.o_full !== 1'b1) begin
      failures++;
      $display("FAIL pp_full_status: got count %0d ovf %b full %b exp 16 0 1",
               bus.o_count, bus.o_overflow, bus.o_full); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (bus.o_head_mask !== evs[i].m || bus.o_head_ts !== evs[i].t) begin failures++;
        $display("FAIL pp_order[%0d]: got %h %0d exp %h %0d", i, bus.o_head_mask, bus.o_head_ts,
                 evs[i].m, evs[i].t); end
      bus.i_pop = 1'b1; tick(); bus.i_pop = 1'b0;
    end
    checks++; if (bus.o_head_mask !== m || bus.o_head_ts !== t || bus.o_count !== 5'd1) begin
      failures++;
      $display("FAIL pp_last: got %h %0d count %0d exp %h %0d 1", bus.o_head_mask, bus.o_head_ts,
               bus.o_count, m, t); end
  endtask

  task automatic test_intl_rst_event();
    logic [TW-1:0] t;
    bus.i_intl_state = '0;
    clear_log();
    evs.delete();
    repeat (17) add_event();
    bus.i_pop = 1'b1; repeat (11) tick(); bus.i_pop = 1'b0;
    checks++; if (bus.o_count !== 5'd5 || bus.o_overflow !== 1'b1) begin failures++;
      $display("FAIL irst_pre: got count %0d ovf %b exp 5 1", bus.o_count, bus.o_overflow); end
    bus.i_intl_state = 16'h0100; bus.i_intl_rst = 1'b1; bus.i_pop = 1'b1; t = mts;
    tick();
    bus.i_intl_rst = 1'b0; bus.i_pop = 1'b0;
    checks++; if (bus.o_count !== 5'd1 || bus.o_overflow !== 1'b0) begin failures++;
      $display("FAIL irst_count: got count %0d ovf %b exp 1 0", bus.o_count, bus.o_overflow); end
    checks++; if (bus.o_first_valid !== 1'b1 || bus.o_first_mask !== 16'h0100 || bus.o_first_ts !== t)
    begin failures++;
      $display("FAIL irst_first: got v=%b %h %0d exp v=1 0100 %0d", bus.o_first_valid,
               bus.o_first_mask, bus.o_first_ts, t); end
    checks++; if (bus.o_head_mask !== 16'h0100 || bus.o_head_ts !== t) begin failures++;
      $display("FAIL irst_head: got %h %0d exp 0100 %0d", bus.o_head_mask, bus.o_head_ts, t); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        bus.i_intl_state = bus.i_intl_state ^ (SW'($urandom) & SW'($urandom) & SW'($urandom));
      bus.i_pop      = (i < 300) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      bus.i_intl_rst = ($urandom_range(0, 59) == 0);
      tick();
      checks++; if (dut_vec !== exp_vec()) begin failures++;
        $display("FAIL rnd[%0d]: got %h exp %h", i, dut_vec, exp_vec()); end
    end
    bus.i_pop = 1'b0; bus.i_intl_rst = 1'b0;
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (dut_vec !== exp_vec()) begin failures++;
      $display("FAIL async_rst: got %h exp %h", dut_vec, exp_vec()); end
    bus.i_intl_state = '0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (dut_vec !== exp_vec()) begin failures++;
      $display("FAIL async_release: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_ts_wrap();
    logic [2:0]    ets [3];
    logic [SW-1:0] ems [3];
    int n;
    ets = '{3'd6, 3'd7, 3'd0};
    ems = '{16'h0001, 16'h0002, 16'h0004};
    n = 0;
    while (sm.o_timestamp != 3'd6 && n < 20) begin tick(); n++; end
    checks++; if (sm.o_timestamp !== 3'd6) begin failures++;
      $display("FAIL wrap_wait: got ts %0d exp 6 within 20 cycles", sm.o_timestamp); end
    sm.i_intl_state = 16'h0001; tick();
    sm.i_intl_state = 16'h0003; tick();
    sm.i_intl_state = 16'h0007; tick();
    checks++; if (sm.o_count !== 3'd3 || sm.o_first_ts !== 3'd6) begin failures++;
      $display("FAIL wrap_count: got count %0d first_ts %0d exp 3 6", sm.o_count, sm.o_first_ts); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (sm.o_head_ts !== ets[i] || sm.o_head_mask !== ems[i]) begin failures++;
        $display("FAIL wrap_entry[%0d]: got %h ts %0d exp %h ts %0d", i, sm.o_head_mask,
                 sm.o_head_ts, ems[i], ets[i]); end
      sm.i_pop = 1'b1; tick(); sm.i_pop = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_first_fault();
    test_two_events();
    test_overflow();
    test_push_pop_full();
    test_intl_rst_event();
    test_random();
    test_async_reset();
    test_ts_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
